// File: rtl/permute_pkg.sv
// ---------------------------------------------------------------------------
// permute_pkg
// Shared constants and the writer state encoding for the permute control unit
// output path.
// ---------------------------------------------------------------------------
package permute_pkg;

  localparam int SLICE_W      = 25;  // one 5x5 slice
  localparam int SLICE_CNT    = 64;  // slices per block
  localparam int SLICE_ADDR_W = 6;   // log2(SLICE_CNT)
  localparam int FIFO_DEPTH   = 4;   // writer buffer entries (power of two)

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_ACK = 2'd2,
    DONE     = 2'd3
  } writer_state_e;

endpackage

// File: rtl/slice_fifo.sv
// ---------------------------------------------------------------------------
// slice_fifo
// Synchronous DEPTH x DATA_W FIFO with a combinational head output.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset (empties the FIFO)
//   clr   in   synchronous clear (empties the FIFO, wins over push/pop)
//   push  in   write din; ignored while full
//   pop   in   drop the head entry; ignored while empty
//   din   in   data to write
//   dout  out  current head entry (valid only when !empty)
//   full  out  count == DEPTH
//   empty out  count == 0
// ---------------------------------------------------------------------------
module slice_fifo #(
  parameter int DATA_W = 25,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q,  count_d;
  logic              push_ok, pop_ok;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;  // idle, or push and pop together
    endcase
  end

  // NOTE: storage has no reset; an entry is only read after it has been
  // written, so clearing it would cost a reset net on every bit for nothing.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem_q[wr_ptr_q] <= din;
  end

  // Pointers are exactly PTR_W bits wide, so they wrap at DEPTH by themselves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/permute_result_writer.sv
// ---------------------------------------------------------------------------
// permute_result_writer
// Captures permuted slices on the permute unit's ready strobe, buffers them
// in a small FIFO and writes them to the output memory one at a time through
// a write/acknowledge handshake with a wrapping slice address. done rises
// after the slice at address SLICES-1 has been acknowledged.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   start     in   one-cycle pulse: clear FIFO/address/done/overflow, run
//   in_valid  in   slice strobe from the permute unit
//   in_data   in   slice captured when in_valid=1
//   full      out  FIFO full; upstream must hold off
//   mem_wr    out  write request (held until mem_ack)
//   mem_addr  out  slice address of the current write
//   mem_data  out  slice being written
//   mem_ack   in   memory accepted the write this cycle
//   done      out  level; whole block written
//   overflow  out  sticky; a strobe arrived while full
// ---------------------------------------------------------------------------
module permute_result_writer
  import permute_pkg::*;
#(
  parameter int DATA_W = SLICE_W,
  parameter int SLICES = SLICE_CNT,
  parameter int ADDR_W = SLICE_ADDR_W,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              full,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
  output logic              done,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SLICES - 1);

  writer_state_e     state_q;
  logic              mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  logic              done_q;
  logic              overflow_q;

  logic              fifo_full, fifo_empty;
  logic              fifo_push, fifo_pop;
  logic [DATA_W-1:0] fifo_dout;
  logic              accepting;

  // Strobes only count while a block is active; start drops a same-cycle strobe.
  assign accepting = ((state_q == RUN) || (state_q == WAIT_ACK)) && !start;
  assign fifo_push = accepting && in_valid && !fifo_full;
  assign fifo_pop  = (state_q == RUN) && !fifo_empty && !start;

  slice_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below reads the pre-edge values of the registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (start) begin
      // A pending write is abandoned; the new block starts at address 0.
      state_q    <= RUN;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (accepting && in_valid && fifo_full) overflow_q <= 1'b1;

      case (state_q)
        IDLE: ;
        RUN: begin
          if (!fifo_empty) begin
            mem_data_q <= fifo_dout;
            mem_wr_q   <= 1'b1;
            state_q    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (mem_ack) begin
            mem_wr_q <= 1'b0;
            if (mem_addr_q == LAST_ADDR) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              mem_addr_q <= mem_addr_q + ADDR_W'(1);
              state_q    <= RUN;
            end
          end
        end
        DONE: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign full     = fifo_full;
  assign mem_wr   = mem_wr_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_permute_result_writer.sv
// ---------------------------------------------------------------------------
// tb_permute_result_writer
// Scoreboard bench: every strobe the writer should accept pushes its expected
// {address, data} pair; every acknowledged write pops and compares one.
// ---------------------------------------------------------------------------
module tb_permute_result_writer;

  localparam int DW = 25;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          full;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_ack;
  logic          done;
  logic          overflow;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q [$];
  exp_t          mon_e;
  logic [AW-1:0] exp_addr;
  int            n_checks = 0;
  int            n_pass   = 0;

  permute_result_writer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .full     (full),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_ack  (mem_ack),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_addr = '0;
  endtask

  // One-cycle strobe; 'accept' says whether the writer must keep this slice.
  task automatic strobe(input logic [DW-1:0] d, input bit accept);
    in_valid = 1'b1;
    in_data  = d;
    if (accept) begin
      exp_q.push_back('{addr: exp_addr, data: d});
      exp_addr = exp_addr + AW'(1);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !mem_wr) break;
      tick();
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Write monitor: a write completes when mem_wr and mem_ack meet at an edge.
  always @(negedge clk) begin
    if (!rst && mem_wr && mem_ack) begin
      check("sb_has_entry", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", mem_addr, mon_e.addr);
        check("wr_data", mem_data, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; mem_ack = 1'b0;
    exp_addr = '0;
    #12;
    check("rst_mem_wr",   mem_wr,   0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_done",     done,     0);
    check("rst_overflow", overflow, 0);
    check("rst_full",     full,     0);
    @(negedge clk); rst = 1'b0;
    tick();

    // Strobes in IDLE are ignored.
    mem_ack = 1'b1;
    strobe(25'h1abcd, 1'b0);
    repeat (4) tick();
    check("idle_no_wr",  mem_wr,   0);
    check("idle_no_ovf", overflow, 0);
    check("idle_full",   full,     0);

    // Basic block: 64 strobes, 4 cycles apart, ack tied high.
    do_start();
    for (int k = 0; k < 64; k++) begin
      strobe(DW'(k), 1'b1);
      repeat (3) tick();
      if (k == 32) check("done_mid", done, 0);
    end
    wait_drain(50);
    check("blk_done",     done,     1);
    check("blk_overflow", overflow, 0);
    check("blk_addr",     mem_addr, 63);

    // Strobes in DONE are ignored and do not set overflow.
    strobe(25'h155, 1'b0);
    repeat (4) tick();
    check("done_no_wr",  mem_wr,   0);
    check("done_no_ovf", overflow, 0);
    check("done_hold",   done,     1);
    check("done_addr",   mem_addr, 63);

    // Second block: done clears the cycle after start, address back to 0.
    do_start();
    check("wrap_done", done,     0);
    check("wrap_addr", mem_addr, 0);
    check("wrap_full", full,     0);

    // mem_ack in RUN with an empty FIFO does nothing.
    mem_ack = 1'b1;
    repeat (3) tick();
    check("run_ack_addr", mem_addr, 0);
    check("run_ack_wr",   mem_wr,   0);

    // Push and pop in the same cycle at count 2.
    mem_ack = 1'b0;
    strobe(25'h100, 1'b1);  // popped into the in-flight write
    strobe(25'h101, 1'b1);
    strobe(25'h102, 1'b1);  // count = 2
    mem_ack = 1'b1;
    tick();                 // ack: back to RUN
    mem_ack = 1'b0;
    strobe(25'h103, 1'b1);  // pop and push together: count stays 2
    strobe(25'h104, 1'b1);  // count 3
    check("pp_not_full", full, 0);
    strobe(25'h105, 1'b1);  // count 4
    check("pp_full", full, 1);
    mem_ack = 1'b1;
    wait_drain(60);
    check("pp_overflow", overflow, 0);
    check("pp_addr",     mem_addr, 6);

    // Backpressure: ack held low while strobes arrive every cycle.
    do_start();
    mem_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      strobe(DW'(32'h200 + i), i < 5);
      if (i == 3) check("bp_full3", full, 0);
      if (i == 4) begin
        check("bp_full4", full,     1);
        check("bp_ovf4",  overflow, 0);
      end
      if (i == 5) check("bp_ovf5", overflow, 1);
    end
    repeat (4) tick();
    check("bp_hold_wr",   mem_wr,   1);
    check("bp_hold_addr", mem_addr, 0);
    check("bp_hold_data", mem_data, 32'h200);
    mem_ack = 1'b1;
    wait_drain(60);
    check("bp_drained_full", full,     0);
    check("bp_ovf_sticky",   overflow, 1);

    // Async reset while waiting for ack at address 17.
    do_start();
    check("start_clr_ovf", overflow, 0);
    for (int k = 0; k < 17; k++) begin
      strobe(DW'(32'h300 + k), 1'b1);
      repeat (3) tick();
    end
    wait_drain(50);
    mem_ack = 1'b0;
    strobe(25'h311, 1'b1);
    tick();
    check("ar_wait_addr", mem_addr, 17);
    check("ar_wait_wr",   mem_wr,   1);
    #3 rst = 1'b1;
    #1;
    check("ar_mem_wr",   mem_wr,   0);
    check("ar_mem_addr", mem_addr, 0);
    check("ar_mem_data", mem_data, 0);
    check("ar_done",     done,     0);
    check("ar_overflow", overflow, 0);
    exp_q.delete();
    #2 rst = 1'b0;
    tick();
    mem_ack = 1'b1;
    strobe(25'h3ff, 1'b0);  // IDLE after reset: ignored
    repeat (3) tick();
    check("ar_idle_wr", mem_wr, 0);
    do_start();
    strobe(25'h0c8, 1'b1);
    wait_drain(20);
    check("ar_resume_addr", mem_addr, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
